// File: rtl/ppi_bus_master_if.sv
// rtl/ppi_bus_master_if.sv - request/response and PPI pin bundle for ppi_bus_master
interface ppi_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rst_req;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic [1:0] A;
  logic [7:0] D_out;
  logic       D_oe;
  logic [7:0] D_in;
  logic       ppi_Reset;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rst_req, D_in,
    output req_ready, rsp_valid, rsp_rdata, busy,
           CS_n, RD_n, WR_n, A, D_out, D_oe, ppi_Reset
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rst_req, D_in,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           CS_n, RD_n, WR_n, A, D_out, D_oe, ppi_Reset
  );
endinterface

// File: rtl/ppi_bus_master.sv
// rtl/ppi_bus_master.sv - 8255 PPI bus-cycle initiator with reset pulse generator
module ppi_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RESET_CYC  = 4
) (
  input  logic              clk,
  input  logic              Reset_n,
  ppi_bus_master_if.master  bus
);

  localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CD  = (HOLD_CYC > RESET_CYC) ? HOLD_CYC : RESET_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  // Counter holds (cycles-1) down to zero, so it only needs to reach MAX_CYC-1.
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, PRST} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          cs_q, cs_d;
  logic          rd_q, rd_d;
  logic          wrn_q, wrn_d;
  logic [1:0]    a_q, a_d;
  logic [7:0]    dout_q, dout_d;
  logic          doe_q, doe_d;
  logic          rv_q, rv_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          prst_q, prst_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  // Next-state and next-output computation; every pin is registered from these.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    rd_d    = rd_q;
    wrn_d   = wrn_q;
    a_d     = a_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    prst_d  = prst_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rst_req) begin
          // Reset pulse wins; a simultaneous request is left pending.
          state_d = PRST;
          cnt_d   = CW'(RESET_CYC - 1);
          prst_d  = 1'b1;
          cs_d    = 1'b1;
        end else if (bus.req_valid && ready_q) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          wr_d    = bus.req_write;
          cs_d    = 1'b0;
          a_d     = bus.req_addr;
          doe_d   = bus.req_write;
          if (bus.req_write) dout_d = bus.req_wdata;
        end else begin
          // ready stays low for the rsp_valid cycle, so there is always one idle gap.
          ready_d = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CW'(STROBE_CYC - 1);
          rd_d    = wr_q;
          wrn_d   = ~wr_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
          rd_d    = 1'b1;
          wrn_d   = 1'b1;
          if (!wr_q) rdata_d = bus.D_in;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cs_d    = 1'b1;
          doe_d   = 1'b0;
          rv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PRST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          prst_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wrn_q   <= 1'b1;
      a_q     <= 2'b00;
      dout_q  <= 8'h00;
      doe_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= 8'h00;
      prst_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wrn_q   <= wrn_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      prst_q  <= prst_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.CS_n      = cs_q;
  assign bus.RD_n      = rd_q;
  assign bus.WR_n      = wrn_q;
  assign bus.A         = a_q;
  assign bus.D_out     = dout_q;
  assign bus.D_oe      = doe_q;
  assign bus.ppi_Reset = prst_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb/tb_ppi_bus_master.sv - randomized self-checking bench for ppi_bus_master
module tb_ppi_bus_master;

  localparam int S     = 1;
  localparam int T     = 2;
  localparam int H     = 1;
  localparam int R     = 4;
  localparam int TOT   = S + T + H;
  localparam int TRACE = TOT + 2;

  logic clk;
  logic Reset_n;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_rdata;

  logic       cs_tr   [1:TRACE];
  logic       rd_tr   [1:TRACE];
  logic       wr_tr   [1:TRACE];
  logic       oe_tr   [1:TRACE];
  logic       rv_tr   [1:TRACE];
  logic [1:0] a_tr    [1:TRACE];
  logic [7:0] dout_tr [1:TRACE];
  logic [7:0] rdat_tr [1:TRACE];

  ppi_bus_master_if bus ();

  ppi_bus_master #(
    .SETUP_CYC  (S),
    .STROBE_CYC (T),
    .HOLD_CYC   (H),
    .RESET_CYC  (R)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request (called at a falling edge) and record TRACE cycles after acceptance.
  task automatic run_cycle(input logic wr, input logic [1:0] ad, input logic [7:0] wd,
                           input logic [7:0] din);
    int guard;
    bus.req_write = wr;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    bus.D_in      = din;
    bus.req_valid = 1'b1;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: req_ready=%b required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= TRACE; k++) begin
      cs_tr[k]   = bus.CS_n;
      rd_tr[k]   = bus.RD_n;
      wr_tr[k]   = bus.WR_n;
      oe_tr[k]   = bus.D_oe;
      rv_tr[k]   = bus.rsp_valid;
      a_tr[k]    = bus.A;
      dout_tr[k] = bus.D_out;
      rdat_tr[k] = bus.rsp_rdata;
      if (k < TRACE) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    logic [25:0] exp_v;
    int bad;
    Reset_n = 1'b0;
    repeat (3) @(negedge clk);
    obs   = {bus.CS_n, bus.RD_n, bus.WR_n, bus.A, bus.D_out, bus.D_oe, bus.rsp_valid,
             bus.rsp_rdata, bus.busy, bus.ppi_Reset, bus.req_ready};
    exp_v = {3'b111, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 3'b000};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs, exp_v);
    end
    Reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b required 1", bus.req_ready);
    end
    // Start a write and pull reset while the strobe is active.
    bus.req_write = 1'b1;
    bus.req_addr  = 2'b10;
    bus.req_wdata = 8'h5A;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.WR_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midwrite_strobe: WR_n=%b required 0", bus.WR_n);
    end
    Reset_n = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.CS_n !== 1'b1 || bus.WR_n !== 1'b1 || bus.D_oe !== 1'b0 || bus.busy !== 1'b0 ||
          bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d bad cycles required 0", bad);
    end
    Reset_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.CS_n !== 1'b1) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_no_rsp: %0d bad cycles required 0", bad);
    end
    exp_rdata = 8'h00;
  endtask

  task automatic test_write();
    int cs_low, wr_bad, d_bad, rv_bad, rd_low;
    run_cycle(1'b1, 2'b11, 8'h80, 8'h00);
    cs_low = 0; wr_bad = 0; d_bad = 0; rv_bad = 0; rd_low = 0;
    for (int k = 1; k <= TRACE; k++) begin
      if (cs_tr[k] === 1'b0) cs_low++;
      if (wr_tr[k] !== ((k >= 2 && k <= 3) ? 1'b0 : 1'b1)) wr_bad++;
      if (k <= TOT && (dout_tr[k] !== 8'h80 || oe_tr[k] !== 1'b1 || a_tr[k] !== 2'b11)) d_bad++;
      if (rv_tr[k] !== ((k == 5) ? 1'b1 : 1'b0)) rv_bad++;
      if (rd_tr[k] === 1'b0) rd_low++;
    end
    n_tests++;
    if (cs_low !== 4 || cs_tr[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL write_cs_window: low=%0d first=%b required 4 and 0", cs_low, cs_tr[1]);
    end
    n_tests++;
    if (wr_bad !== 0 || rd_low !== 0) begin
      n_fail++;
      $display("FAIL write_strobe: wr_bad=%0d rd_low=%0d required 0 0", wr_bad, rd_low);
    end
    n_tests++;
    if (d_bad !== 0) begin
      n_fail++;
      $display("FAIL write_data: %0d bad cycles required 0", d_bad);
    end
    n_tests++;
    if (rv_bad !== 0) begin
      n_fail++;
      $display("FAIL write_rsp: %0d bad cycles required 0", rv_bad);
    end
  endtask

  task automatic test_read();
    int rd_bad, wr_low, oe_on, rv_bad;
    run_cycle(1'b0, 2'b01, 8'h00, 8'hA5);
    exp_rdata = 8'hA5;
    rd_bad = 0; wr_low = 0; oe_on = 0; rv_bad = 0;
    for (int k = 1; k <= TRACE; k++) begin
      if (rd_tr[k] !== ((k >= 2 && k <= 3) ? 1'b0 : 1'b1)) rd_bad++;
      if (wr_tr[k] === 1'b0) wr_low++;
      if (oe_tr[k] === 1'b1) oe_on++;
      if (rv_tr[k] !== ((k == 5) ? 1'b1 : 1'b0)) rv_bad++;
    end
    n_tests++;
    if (rd_bad !== 0 || wr_low !== 0) begin
      n_fail++;
      $display("FAIL read_strobe: rd_bad=%0d wr_low=%0d required 0 0", rd_bad, wr_low);
    end
    n_tests++;
    if (oe_on !== 0) begin
      n_fail++;
      $display("FAIL read_doe: %0d cycles driven required 0", oe_on);
    end
    n_tests++;
    if (rv_bad !== 0) begin
      n_fail++;
      $display("FAIL read_rsp: %0d bad cycles required 0", rv_bad);
    end
    n_tests++;
    if (rdat_tr[5] !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_data: got %h required a5", rdat_tr[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic       cs_b   [0:19];
    logic [7:0] dout_b [0:19];
    int accepts, rb_bad, runs, gap;
    int st [0:3];
    int en [0:3];
    bus.req_write = 1'b1;
    bus.req_addr  = 2'b00;
    bus.req_wdata = 8'h11;
    bus.req_valid = 1'b1;
    accepts = 0; rb_bad = 0; runs = 0;
    for (int c = 0; c < 20; c++) begin
      cs_b[c]   = bus.CS_n;
      dout_b[c] = bus.D_out;
      if (bus.req_ready === 1'b1 && bus.busy === 1'b1) rb_bad++;
      if (bus.req_ready === 1'b1 && bus.req_valid === 1'b1) accepts++;
      @(negedge clk);
      if (accepts == 1) begin
        bus.req_addr  = 2'b10;
        bus.req_wdata = 8'h22;
      end
      if (accepts >= 2) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (cs_b[c] === 1'b0 && (c == 0 || cs_b[c-1] !== 1'b0)) begin
        if (runs < 4) st[runs] = c;
      end
      if (cs_b[c] === 1'b0 && (c == 19 || cs_b[c+1] !== 1'b0)) begin
        if (runs < 4) en[runs] = c;
        runs++;
      end
    end
    n_tests++;
    if (accepts !== 2) begin
      n_fail++;
      $display("FAIL b2b_accepts: got %0d required 2", accepts);
    end
    n_tests++;
    if (rb_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_ready_while_busy: %0d cycles required 0", rb_bad);
    end
    n_tests++;
    if (runs !== 2) begin
      n_fail++;
      $display("FAIL b2b_windows: got %0d required 2", runs);
    end else begin
      gap = st[1] - en[0] - 1;
      n_tests++;
      if ((en[0] - st[0] + 1) !== TOT || (en[1] - st[1] + 1) !== TOT || gap < 1) begin
        n_fail++;
        $display("FAIL b2b_timing: len0=%0d len1=%0d gap=%0d required %0d %0d >=1",
                 en[0] - st[0] + 1, en[1] - st[1] + 1, gap, TOT, TOT);
      end
      n_tests++;
      if (dout_b[st[1]] !== 8'h22 || dout_b[st[0]] !== 8'h11) begin
        n_fail++;
        $display("FAIL b2b_data: got %h %h required 11 22", dout_b[st[0]], dout_b[st[1]]);
      end
    end
  endtask

  task automatic test_priority();
    int prst_bad, cs_bad, rv_cnt;
    bus.req_write = 1'b1;
    bus.req_addr  = 2'b00;
    bus.req_wdata = 8'h3C;
    bus.rst_req   = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.rst_req = 1'b0;
    prst_bad = 0; cs_bad = 0;
    for (int k = 1; k <= R + 1; k++) begin
      if (bus.ppi_Reset !== ((k <= R) ? 1'b1 : 1'b0)) prst_bad++;
      if (bus.CS_n !== 1'b1) cs_bad++;
      @(negedge clk);
    end
    n_tests++;
    if (prst_bad !== 0) begin
      n_fail++;
      $display("FAIL prio_reset_pulse: %0d bad cycles required 0", prst_bad);
    end
    n_tests++;
    if (cs_bad !== 0) begin
      n_fail++;
      $display("FAIL prio_cs_idle: %0d bad cycles required 0", cs_bad);
    end
    // The pending request is still held and is taken once the pulse ends.
    n_tests++;
    if (bus.CS_n !== 1'b0 || bus.D_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL prio_request_kept: CS_n=%b D_out=%h required 0 3c", bus.CS_n, bus.D_out);
    end
    bus.req_valid = 1'b0;
    rv_cnt = 0;
    repeat (TRACE) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) rv_cnt++;
    end
    n_tests++;
    if (rv_cnt !== 1) begin
      n_fail++;
      $display("FAIL prio_rsp_count: got %0d required 1", rv_cnt);
    end
  endtask

  task automatic test_random();
    logic       wr;
    logic [1:0] ad;
    logic [7:0] wd, din;
    logic       e_rd, e_wr;
    int tim_bad, rv_bad, a_bad, d_bad, proto_bad;
    for (int t = 0; t < 40; t++) begin
      wr  = 1'($urandom_range(0, 1));
      ad  = 2'($urandom_range(0, 3));
      wd  = 8'($urandom_range(0, 255));
      din = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_cycle(wr, ad, wd, din);
      if (!wr) exp_rdata = din;
      tim_bad = 0; rv_bad = 0; a_bad = 0; d_bad = 0; proto_bad = 0;
      for (int k = 1; k <= TRACE; k++) begin
        e_rd = (!wr && k > S && k <= S + T) ? 1'b0 : 1'b1;
        e_wr = (wr && k > S && k <= S + T) ? 1'b0 : 1'b1;
        if (cs_tr[k] !== ((k <= TOT) ? 1'b0 : 1'b1) || rd_tr[k] !== e_rd || wr_tr[k] !== e_wr)
          tim_bad++;
        if (rv_tr[k] !== ((k == TOT + 1) ? 1'b1 : 1'b0)) rv_bad++;
        if (k <= TOT && a_tr[k] !== ad) a_bad++;
        if (k <= TOT && oe_tr[k] !== wr) d_bad++;
        if (k > TOT && oe_tr[k] !== 1'b0) d_bad++;
        if (k <= TOT && wr && dout_tr[k] !== wd) d_bad++;
        if (rd_tr[k] === 1'b0 && wr_tr[k] === 1'b0) proto_bad++;
        if (!wr && oe_tr[k] === 1'b1) proto_bad++;
        if (k > 1 && cs_tr[k] === 1'b0 && cs_tr[k-1] === 1'b0 && a_tr[k] !== a_tr[k-1]) proto_bad++;
      end
      n_tests++;
      if (tim_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_timing t=%0d: %0d bad cycles required 0", t, tim_bad);
      end
      n_tests++;
      if (rv_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_rsp t=%0d: %0d bad cycles required 0", t, rv_bad);
      end
      n_tests++;
      if (a_bad !== 0 || d_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_addr_data t=%0d: a_bad=%0d d_bad=%0d required 0 0", t, a_bad, d_bad);
      end
      n_tests++;
      if (proto_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_protocol t=%0d: %0d violations required 0", t, proto_bad);
      end
      n_tests++;
      if (rdat_tr[TOT + 1] !== exp_rdata) begin
        n_fail++;
        $display("FAIL rand_rdata t=%0d: got %h required %h", t, rdat_tr[TOT + 1], exp_rdata);
      end
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    exp_rdata     = 8'h00;
    Reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 2'b00;
    bus.req_wdata = 8'h00;
    bus.rst_req   = 1'b0;
    bus.D_in      = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_priority();
    repeat (2) @(negedge clk);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
